// File: rtl/rob_ctrl.sv
// ROB sequencer: head/tail/count/valid bookkeeping, one-hot line enables, commit handshake.
// Combinational enables, registered pointers; flush wins and costs one dead cycle (FLUSH). Optional macro: ROB_PERF_CNT_EN.
module rob_ctrl #(
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_req,
    output logic                  alloc_ready,
    output logic [ADDR_WIDTH-1:0] alloc_idx,
    output logic [DEPTH-1:0]      line_write_en,
    input  logic                  update_en_in,
    input  logic [ADDR_WIDTH-1:0] update_idx,
    output logic [DEPTH-1:0]      line_update_en,
    input  logic [DEPTH-1:0]      line_done,
    output logic                  commit_valid,
    output logic [ADDR_WIDTH-1:0] commit_idx,
    input  logic                  commit_ack,
    input  logic                  flush,
`ifdef ROB_PERF_CNT_EN
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_commit_cnt,
`endif
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty
);

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [DEPTH-1:0]      OH_ONE   = DEPTH'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] head_q, head_d;
    logic [ADDR_WIDTH-1:0] tail_q, tail_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DEPTH-1:0]      valid_q, valid_d;

    logic alloc_fire;
    logic commit_fire;
    logic run;

    assign run   = (state_q == RUN);
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign count = count_q;

    // Registered count only: a commit this cycle never frees room for an alloc this cycle.
    assign alloc_ready = run && !full;
    assign alloc_idx   = tail_q;
    assign alloc_fire  = alloc_req && alloc_ready && !flush;
    assign line_write_en = alloc_fire ? (OH_ONE << tail_q) : '0;

    assign line_update_en = (update_en_in && valid_q[update_idx] && run && !flush)
                          ? (OH_ONE << update_idx) : '0;

    assign commit_idx   = head_q;
    assign commit_valid = run && !flush && valid_q[head_q] && line_done[head_q];
    assign commit_fire  = commit_ack && commit_valid;

    always_comb begin
        state_d = RUN;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (flush) begin
            state_d = FLUSH;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = '0;
        end else begin
            // Head and tail cannot collide here: a commit needs a valid head, an alloc an invalid tail.
            if (commit_fire) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + PTR_ONE;
            end
            if (alloc_fire) begin
                valid_d[tail_q] = 1'b1;
                tail_d          = tail_q + PTR_ONE;
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

`ifdef ROB_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] commit_cnt_q, commit_cnt_d;

    // Saturating; flush deliberately leaves the statistics alone.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        commit_cnt_d = commit_cnt_q;
        if (alloc_req && !alloc_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (commit_fire && (commit_cnt_q != 32'hFFFF_FFFF)) begin
            commit_cnt_d = commit_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q  <= '0;
            commit_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            commit_cnt_q <= commit_cnt_d;
        end
    end

    assign perf_stall_cnt  = stall_cnt_q;
    assign perf_commit_cnt = commit_cnt_q;
`endif

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed bench for rob_ctrl: allocation indices go through a scoreboard queue, everything else is checked against constants.
module tb_rob_ctrl;

    localparam int AW = 3;
    localparam int D  = 1 << AW;

    logic          clk;
    logic          rst;
    logic          alloc_req;
    logic          alloc_ready;
    logic [AW-1:0] alloc_idx;
    logic [D-1:0]  line_write_en;
    logic          update_en_in;
    logic [AW-1:0] update_idx;
    logic [D-1:0]  line_update_en;
    logic [D-1:0]  line_done;
    logic          commit_valid;
    logic [AW-1:0] commit_idx;
    logic          commit_ack;
    logic          flush;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
`ifdef ROB_PERF_CNT_EN
    logic [31:0]   perf_stall_cnt;
    logic [31:0]   perf_commit_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] exp_q[$];

    rob_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_req      (alloc_req),
        .alloc_ready    (alloc_ready),
        .alloc_idx      (alloc_idx),
        .line_write_en  (line_write_en),
        .update_en_in   (update_en_in),
        .update_idx     (update_idx),
        .line_update_en (line_update_en),
        .line_done      (line_done),
        .commit_valid   (commit_valid),
        .commit_idx     (commit_idx),
        .commit_ack     (commit_ack),
        .flush          (flush),
`ifdef ROB_PERF_CNT_EN
        .perf_stall_cnt (perf_stall_cnt),
        .perf_commit_cnt(perf_commit_cnt),
`endif
        .count          (count),
        .full           (full),
        .empty          (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pops one expected index per observed write enable.
    task automatic see_write();
        logic [AW-1:0] e;
        logic [D-1:0]  oh;
        if (line_write_en != '0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(line_write_en), 32'd0);
            end else begin
                e  = exp_q.pop_front();
                oh = '0;
                oh[e] = 1'b1;
                chk("alloc_idx", 32'(alloc_idx), 32'(e));
                chk("write_en", 32'(line_write_en), 32'(oh));
            end
        end else begin
            chk("missing_write", 32'(line_write_en), 32'(exp_q.size() != 0));
        end
    endtask

    task automatic do_alloc(input int idx);
        @(negedge clk);
        alloc_req = 1'b1;
        exp_q.push_back(AW'(idx));
        #1;
        chk("alloc_ready", 32'(alloc_ready), 32'd1);
        see_write();
    endtask

    initial begin
        rst = 1'b0; alloc_req = 1'b0; update_en_in = 1'b0; update_idx = '0;
        line_done = '0; commit_ack = 1'b0; flush = 1'b0;
        #12;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        chk("rst_commit_valid", 32'(commit_valid), 32'd0);
        chk("rst_write_en", 32'(line_write_en), 32'd0);
        chk("rst_update_en", 32'(line_update_en), 32'd0);
        chk("rst_alloc_idx", 32'(alloc_idx), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 3; i++) do_alloc(i);
        @(negedge clk);
        alloc_req = 1'b0; update_en_in = 1'b1; update_idx = 3'd2;
        #1;
        chk("upd_valid", 32'(line_update_en), 32'h04);
        update_idx = 3'd5;
        #1;
        chk("upd_invalid", 32'(line_update_en), 32'h00);
        update_en_in = 1'b0;
        chk("count3", 32'(count), 32'd3);

        for (int i = 3; i < 8; i++) do_alloc(i);
        @(negedge clk);
        #1;
        chk("full_count", 32'(count), 32'd8);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_alloc_ready", 32'(alloc_ready), 32'd0);
        chk("ninth_write_en", 32'(line_write_en), 32'd0);
        chk("sb_drained_a", 32'(exp_q.size()), 32'd0);

        alloc_req = 1'b0; line_done = 8'h02;
        #1;
        chk("out_of_order_done", 32'(commit_valid), 32'd0);
        line_done = 8'h03;
        #1;
        chk("head_done_valid", 32'(commit_valid), 32'd1);
        chk("head_idx0", 32'(commit_idx), 32'd0);
        commit_ack = 1'b1; alloc_req = 1'b1;
        #1;
        chk("full_ack_ready", 32'(alloc_ready), 32'd0);
        chk("full_ack_write", 32'(line_write_en), 32'd0);

        @(negedge clk);
        commit_ack = 1'b0;
        exp_q.push_back(3'd0);
        #1;
        chk("after_ack_count", 32'(count), 32'd7);
        chk("after_ack_head", 32'(commit_idx), 32'd1);
        chk("after_ack_ready", 32'(alloc_ready), 32'd1);
        see_write();
        @(negedge clk);
        alloc_req = 1'b0;
        #1;
        chk("refill_count", 32'(count), 32'd8);
        chk("refill_full", 32'(full), 32'd1);

        line_done = '1; commit_ack = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            chk("drain_valid", 32'(commit_valid), 32'd1);
            chk("drain_idx", 32'(commit_idx), 32'(i));
            @(negedge clk);
            #1;
        end
        chk("count_at3", 32'(count), 32'd3);
        alloc_req = 1'b1;
        exp_q.push_back(3'd1);
        #1;
        see_write();
        chk("simul_commit_idx", 32'(commit_idx), 32'd6);
        @(negedge clk);
        alloc_req = 1'b0;
        #1;
        chk("simul_count", 32'(count), 32'd3);
        chk("simul_head", 32'(commit_idx), 32'd7);
        chk("simul_tail", 32'(alloc_idx), 32'd2);
        @(negedge clk);
        commit_ack = 1'b0;
        #1;
        chk("head_wrap", 32'(commit_idx), 32'd0);
        chk("wrap_count", 32'(count), 32'd2);

        for (int i = 2; i < 5; i++) do_alloc(i);
        @(negedge clk);
        alloc_req = 1'b1; flush = 1'b1; update_en_in = 1'b1; update_idx = 3'd0;
        #1;
        chk("pre_flush_count", 32'(count), 32'd5);
        chk("flush_write_en", 32'(line_write_en), 32'd0);
        chk("flush_commit_valid", 32'(commit_valid), 32'd0);
        chk("flush_update_en", 32'(line_update_en), 32'd0);
        @(negedge clk);
        flush = 1'b0; update_en_in = 1'b0;
        #1;
        chk("flushed_count", 32'(count), 32'd0);
        chk("flushed_empty", 32'(empty), 32'd1);
        chk("flushstate_ready", 32'(alloc_ready), 32'd0);
        chk("flushstate_write", 32'(line_write_en), 32'd0);
        chk("flushstate_commit", 32'(commit_valid), 32'd0);
        @(negedge clk);
        exp_q.push_back(3'd0);
        #1;
        chk("post_flush_ready", 32'(alloc_ready), 32'd1);
        see_write();

        @(negedge clk);
        alloc_req = 1'b0; line_done = '0; commit_ack = 1'b1;
        #1;
        chk("one_entry", 32'(count), 32'd1);
        chk("not_done_valid", 32'(commit_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("ack_ignored", 32'(count), 32'd1);
        commit_ack = 1'b0; line_done = '1;
        #1;
        chk("pre_reset_valid", 32'(commit_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_empty", 32'(empty), 32'd1);
        chk("async_rst_commit", 32'(commit_valid), 32'd0);
        chk("sb_drained_end", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rob_ctrl.md
Name: rob_ctrl

Overview:
Sequencer for an array of 2**ADDR_WIDTH ROB line storage entries, used as a circular buffer. It owns the head/tail pointers, occupancy and per-entry valid bits. It generates the one-hot write and update enables that drive the lines, and presents the head entry to the commit stage with a valid/ack handshake. It sits between dispatch, the writeback/CDB, the commit stage and the ROB line array, and handles pipeline flush on exception or branch mispredict.

Parameters:
ADDR_WIDTH, 3, entry index width; DEPTH = 2**ADDR_WIDTH (8)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
alloc_req  in  1  dispatch requests one entry this cycle
alloc_ready  out  1  entry available; allocation happens when alloc_req && alloc_ready
alloc_idx  out  ADDR_WIDTH  index granted (current tail)
line_write_en  out  DEPTH  one-hot write_en to the line array
update_en_in  in  1  writeback result valid
update_idx  in  ADDR_WIDTH  entry being completed
line_update_en  out  DEPTH  one-hot update_en to the line array
line_done  in  DEPTH  done flag of each line
commit_valid  out  1  head entry valid and done
commit_idx  out  ADDR_WIDTH  head index
commit_ack  in  1  commit stage retires head; acts only with commit_valid
flush  in  1  discard all entries
count  out  ADDR_WIDTH+1  occupied entries
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset (rst low, asynchronous): head=0, tail=0, count=0, valid=0, state=RUN. All outputs derived from these: alloc_ready=1, full=0, empty=1, commit_valid=0, line_* enables=0.
- State machine with two states:
  - RUN: normal operation.
  - FLUSH: entered for exactly one cycle after flush is sampled. In this state alloc_ready=0 and commit_valid=0, and the block then returns to RUN.
- Allocation:
  - alloc_ready = (state==RUN) && !full, computed from registered count only. A same-cycle commit does not free space for a same-cycle allocation.
  - line_write_en = alloc_req && alloc_ready ? (1<<tail) : 0, combinational, same cycle.
  - On the clock edge: valid[tail]=1, tail = tail+1 mod DEPTH (natural wrap).
- Update:
  - line_update_en = update_en_in && valid[update_idx] && state==RUN ? (1<<update_idx) : 0, combinational.
  - Updates to invalid entries are silently dropped.
  - An update can never target the tail line in the same cycle as an allocation, because the tail line is invalid.
- Commit:
  - commit_valid = state==RUN && valid[head] && line_done[head].
  - commit_idx = head.
  - On commit_ack && commit_valid: valid[head]=0, head = head+1 mod DEPTH.
  - commit_ack without commit_valid is ignored.
- Count: alloc only → +1; commit only → -1; both → unchanged.
- Flush has highest priority:
  - A flush sampled at an edge sets head=0, tail=0, count=0, valid=0 and state=FLUSH.
  - Any alloc or commit in the same cycle is discarded.
  - The line_write_en, line_update_en and commit_valid outputs are forced to 0 while flush=1.
- Boundaries:
  - full with commit_ack: the entry retires and alloc_ready rises next cycle.
  - empty: commit_valid=0.
  - Pointer wrap from DEPTH-1 to 0 is seamless.
  - A reset in the middle of a flush or commit returns the block to the reset state immediately.

Optional Feature:
ROB_PERF_CNT_EN:
- When defined, add two outputs:
  - perf_stall_cnt (32): increments every cycle with alloc_req && !alloc_ready.
  - perf_commit_cnt (32): increments on every retired commit.
- Both counters saturate at 32'hFFFFFFFF, are cleared by reset, and are not cleared by flush.
- When undefined, the ports and logic are absent.

Test Plan:
- Reset, then 8 consecutive alloc_req → alloc_idx 0..7 with line_write_en 8'h01..8'h80; count=8, full=1, alloc_ready=0; a 9th request produces no write enable.
- update_idx=2 while entries 0..2 are valid → line_update_en=8'h04. update_idx=5 while entry 5 is invalid → line_update_en=0.
- Completion order: line_done[1]=1 while line_done[0]=0 → commit_valid=0. Then line_done[0]=1 → commit_valid=1 with commit_idx=0; ack → head=1, count decrements.
- Full buffer, commit_ack and alloc_req in the same cycle → no allocation that cycle; count 8→7; next cycle alloc_idx=0 (wrap) is granted and count returns to 8.
- Simultaneous alloc and commit at count=3 → count stays 3, head+1, tail+1.
- flush with count=5 and alloc_req=1 → line_write_en=0 that cycle. Next cycle: count=0, empty=1, alloc_ready=0 (FLUSH). The cycle after: alloc_ready=1 and alloc_idx=0.
